// File: rtl/load_store_unit.sv
// Load/store unit with an in-order store buffer that drains to data memory when no load uses the port.
// Define LSU_STORE_FWD_EN to forward buffered store data to loads; otherwise loads wait for an empty buffer.
`ifndef ASIZE
`define ASIZE 8
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

module load_store_unit #(
  parameter int SB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [`ASIZE-1:0]             req_addr,
  input  logic [`DSIZE-1:0]             req_wdata,
  output logic                          rsp_valid,
  output logic [`DSIZE-1:0]             rsp_rdata,
  output logic                          dm_ren,
  output logic                          dm_wen,
  output logic [`ASIZE-1:0]             dm_addr,
  output logic [`DSIZE-1:0]             dm_wdata,
  input  logic [`DSIZE-1:0]             dm_rdata,
  output logic [$clog2(SB_DEPTH):0]     sb_count
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(SB_DEPTH);

  logic [SB_DEPTH-1:0][`ASIZE-1:0] sb_addr;
  logic [SB_DEPTH-1:0][`DSIZE-1:0] sb_data;
  logic [PW-1:0]     head, tail;
  logic              vld_q, pend_mem;
  logic [`DSIZE-1:0] rdata_q;
  logic              load_ok, store_acc, load_acc, mem_load, drain;

`ifdef LSU_STORE_FWD_EN
  logic              fwd_hit;
  logic [`DSIZE-1:0] fwd_data;
  logic [PW-1:0]     idx;

  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head + PW'(i);
      if ((PW+1)'(i) < sb_count && sb_addr[idx] == req_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[idx];
      end
    end
  end

  assign load_ok  = 1'b1;
  assign mem_load = load_acc && !fwd_hit;
`else
  assign load_ok  = (sb_count == '0);
  assign mem_load = load_acc;
`endif

  assign req_ready = !rst && (req_we ? (sb_count < FULL) : load_ok);
  assign store_acc = req_valid && req_ready && req_we;
  assign load_acc  = req_valid && req_ready && !req_we;
  assign drain     = !rst && (sb_count != '0) && !mem_load;

  assign dm_ren    = mem_load;
  assign dm_wen    = drain;
  assign dm_addr   = mem_load ? req_addr : sb_addr[head];
  assign dm_wdata  = sb_data[head];
  assign rsp_valid = vld_q && !rst;
  assign rsp_rdata = pend_mem ? dm_rdata : rdata_q;

  always_ff @(posedge clk) begin
    if (store_acc) begin
      sb_addr[tail] <= req_addr;
      sb_data[tail] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      sb_count <= '0;
      vld_q    <= 1'b0;
      pend_mem <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (store_acc) tail <= tail + 1'b1;
      if (drain)     head <= head + 1'b1;
      case ({store_acc, drain})
        2'b10:   sb_count <= sb_count + 1'b1;
        2'b01:   sb_count <= sb_count - 1'b1;
        default: ;
      endcase
      vld_q    <= load_acc;
      pend_mem <= mem_load;
      // Memory data lands in the hold register after its response cycle; a newer forward overrides it.
      if (pend_mem) rdata_q <= dm_rdata;
`ifdef LSU_STORE_FWD_EN
      if (load_acc && !mem_load) rdata_q <= fwd_data;
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: program-order reference memory plus store scoreboard, checked every cycle.
`ifndef ASIZE
`define ASIZE 8
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

module tb_load_store_unit;
  localparam int SB_DEPTH = 4;
  localparam int A = `ASIZE;
  localparam int D = `DSIZE;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [A-1:0] req_addr = '0, dm_addr;
  logic [D-1:0] req_wdata = '0, rsp_rdata, dm_wdata, dm_rdata = '0;
  logic rsp_valid, dm_ren, dm_wen;
  logic [$clog2(SB_DEPTH):0] sb_count;

  load_store_unit #(.SB_DEPTH(SB_DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .dm_ren(dm_ren), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .sb_count(sb_count));

  always #5 clk = ~clk;

  logic [D-1:0] mem    [0:(1<<A)-1];
  logic [D-1:0] refmem [0:(1<<A)-1];

  // Data memory with registered read.
  always @(posedge clk) begin
    if (dm_ren) dm_rdata <= mem[dm_addr];
    if (dm_wen) mem[dm_addr] <= dm_wdata;
  end

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct { logic [A-1:0] a; logic [D-1:0] d; } st_t;
  st_t sbq[$];
  logic         exp_pend = 1'b0;
  logic [D-1:0] exp_rd = '0, last_rd = '0;

  always @(negedge clk) begin
    int  n;
    logic hit, acc_ld, acc_st, exp_rdy, exp_ren;
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_ren", 32'(dm_ren), 0);
      chk("rst_wen", 32'(dm_wen), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      sbq.delete();
      exp_pend = 1'b0;
      last_rd  = '0;
      for (int i = 0; i < (1<<A); i++) refmem[i] = mem[i];
    end else begin
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_pend));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_pend ? exp_rd : last_rd));
      chk("ren_wen_excl", 32'(dm_ren && dm_wen), 0);
      n = sbq.size();
      chk("sb_count", 32'(sb_count), 32'(n));
      hit = 1'b0;
      for (int i = 0; i < n; i++) if (sbq[i].a == req_addr) hit = 1'b1;
      if (req_valid) begin
`ifdef LSU_STORE_FWD_EN
        exp_rdy = req_we ? (n < SB_DEPTH) : 1'b1;
`else
        exp_rdy = req_we ? (n < SB_DEPTH) : (n == 0);
`endif
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      end
      acc_ld = req_valid && req_ready && !req_we;
      acc_st = req_valid && req_ready && req_we;
`ifdef LSU_STORE_FWD_EN
      exp_ren = acc_ld && !hit;
`else
      exp_ren = acc_ld;
`endif
      chk("dm_ren", 32'(dm_ren), 32'(exp_ren));
      if (exp_ren) chk("dm_addr_rd", 32'(dm_addr), 32'(req_addr));
      chk("dm_wen", 32'(dm_wen), 32'(n > 0 && !exp_ren));
      if (dm_wen && n > 0) begin
        chk("drain_addr", 32'(dm_addr), 32'(sbq[0].a));
        chk("drain_data", 32'(dm_wdata), 32'(sbq[0].d));
        void'(sbq.pop_front());
      end
      if (acc_st) begin
        sbq.push_back('{req_addr, req_wdata});
        refmem[req_addr] = req_wdata;
      end
      if (exp_pend) last_rd = exp_rd;
      exp_pend = acc_ld;
      if (acc_ld) exp_rd = refmem[req_addr];
    end
  end

  // Present a request at posedge+1 and hold it until accepted; returns at posedge+1 after acceptance.
  task automatic do_req(input logic we, input logic [A-1:0] a, input logic [D-1:0] d, output logic ren);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; ren = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready) begin
        ren = dm_ren;
        @(posedge clk); #1;
        req_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errs++;
    $display("FAIL req_timeout: got no accept expected accept within 200 cycles addr %0h", a);
    req_valid = 1'b0;
  endtask

  initial begin
    logic ren;
    for (int i = 0; i < (1<<A); i++) mem[i] = D'($urandom);
    mem[8'h05] = 16'h1234;
    mem[8'h20] = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Memory load: dm_ren in T, data in T+1.
    do_req(1'b0, 8'h05, '0, ren);
    chk("t_load_ren", 32'(ren), 1);
    @(negedge clk);
    chk("t_load_rsp_v", 32'(rsp_valid), 1);
    chk("t_load_rsp_d", 32'(rsp_rdata), 32'h1234);
    @(posedge clk); #1;

    // Two stores to one address then a load of it.
    do_req(1'b1, 8'h0A, 16'h1111, ren);
    do_req(1'b1, 8'h0A, 16'h2222, ren);
    do_req(1'b0, 8'h0A, '0, ren);
`ifdef LSU_STORE_FWD_EN
    chk("fwd_no_ren", 32'(ren), 0);
`else
    chk("drained_ren", 32'(ren), 1);
`endif
    @(negedge clk);
    chk("same_addr_rsp_v", 32'(rsp_valid), 1);
    chk("same_addr_rsp_d", 32'(rsp_rdata), 32'h2222);
    @(posedge clk); #1;

    // Reset with a buffered store: it must never reach memory.
    do_req(1'b1, 8'h20, 16'hBEEF, ren);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_store_no_wen", 32'(dm_wen), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_sb_count", 32'(sb_count), 0);
    chk("rst_rsp_clear", 32'(rsp_valid), 0);
    @(posedge clk); #1;

    // Reset one cycle after a load is accepted kills its response.
    do_req(1'b0, 8'h30, '0, ren);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_kill_rsp", 32'(rsp_valid), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_store_dropped", 32'(mem[8'h20]), 0);

    // Random mix on a small address window so loads hit buffered stores.
    for (int n = 0; n < 1000; n++) begin
      do_req(1'($urandom_range(0, 1)), A'($urandom_range(0, 15)), D'($urandom), ren);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
    end
    repeat (SB_DEPTH + 4) @(posedge clk);
    #1;
    chk("final_drained", 32'(sb_count), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
